// File: rtl/riscv_pkg.sv
// Base RISC-V types shared by the integer pipeline.
package riscv_pkg;
    typedef logic [4:0]  reg_t;
    typedef logic [31:0] data_t;
endpackage

// File: rtl/tortoise_pkg.sv
// Core-level configuration constants and shared commit-stage types.
package tortoise_pkg;
    import riscv_pkg::*;

    localparam int unsigned GPREG_WB_REQUESTERS = 4;

    typedef struct packed {
        reg_t  rd;
        data_t data;
    } wb_req_t;
endpackage

// File: rtl/gpreg_wb_arbiter_rr_arbiter.sv
// Combinational arbiter: first requester at or after ptr_i (wrapping), or
// the lowest requester when fixed_prio_i is set.
module rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic          fixed_prio_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          gnt_any_o
);
    logic [IW:0] start;
    logic [IW:0] cand;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_any_o = 1'b0;
        cand      = '0;
        start     = fixed_prio_i ? '0 : {1'b0, ptr_i};
        for (int unsigned i = 0; i < N; i++) begin
            cand = start + (IW+1)'(i);
            // Explicit wrap so non-power-of-two N never lands on a phantom slot.
            if (cand > (IW+1)'(N - 1)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!gnt_any_o && req_i[cand[IW-1:0]]) begin
                gnt_any_o = 1'b1;
                gnt_idx_o = cand[IW-1:0];
            end
        end
        if (gnt_any_o) begin
            gnt_o[gnt_idx_o] = 1'b1;
        end
    end
endmodule

// File: rtl/gpreg_wb_arbiter.sv
// Write-back arbiter sharing the GPR write port among result producers.
// Build option: GPREG_WB_FIXED_PRIO_EN selects lowest-index-wins instead of round-robin.
module gpreg_wb_arbiter
    import riscv_pkg::*;
    import tortoise_pkg::*;
#(
    parameter  int unsigned NR_REQ = GPREG_WB_REQUESTERS,
    localparam int unsigned IDX_W  = $clog2(NR_REQ)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic [NR_REQ-1:0]        req_valid_i,
    input  reg_t  [NR_REQ-1:0]       req_reg_i,
    input  data_t [NR_REQ-1:0]       req_data_i,
    output logic [NR_REQ-1:0]        req_ready_o,
    output logic                     w_en_o,
    output reg_t                     w_reg_o,
    output data_t                    w_data_o,
    output logic [IDX_W-1:0]         grant_idx_o
);
    // Handshake: a producer raises valid and holds valid/reg/data stable until it
    // sees ready; ready depends on valid combinationally, never the reverse; a
    // transfer happens on every clock edge where valid & ready are both high.

    logic [NR_REQ-1:0] gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_any;
    logic              fixed_prio;
    logic [IDX_W-1:0]  rr_ptr_q;
    logic              transfer;
    logic              w_en_d, w_en_q;
    wb_req_t           wb_d, wb_q;

    rr_arbiter #(.N(NR_REQ)) u_rr_arbiter (
        .req_i       (req_valid_i),
        .ptr_i       (rr_ptr_q),
        .fixed_prio_i(fixed_prio),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx),
        .gnt_any_o   (gnt_any)
    );

    always_comb begin
        req_ready_o = '0;
        grant_idx_o = '0;
        if (rst_ni && !flush_i) begin
            req_ready_o = gnt;
            grant_idx_o = gnt_idx;
        end
    end

    assign transfer = rst_ni && !flush_i && gnt_any;

`ifdef GPREG_WB_FIXED_PRIO_EN
    assign fixed_prio = 1'b1;
    assign rr_ptr_q   = '0;
`else
    logic [IDX_W-1:0] rr_ptr_d;
    assign fixed_prio = 1'b0;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (flush_i) begin
            rr_ptr_d = '0;
        end else if (transfer) begin
            rr_ptr_d = (gnt_idx == IDX_W'(NR_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // Writes to x0 are accepted but discarded; the port keeps its last reg/data.
    always_comb begin
        w_en_d = transfer && (req_reg_i[gnt_idx] != '0);
        wb_d   = wb_q;
        if (w_en_d) begin
            wb_d.rd   = req_reg_i[gnt_idx];
            wb_d.data = req_data_i[gnt_idx];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_en_q <= 1'b0;
            wb_q   <= '0;
        end else begin
            w_en_q <= w_en_d;
            wb_q   <= wb_d;
        end
    end

    assign w_en_o   = w_en_q;
    assign w_reg_o  = wb_q.rd;
    assign w_data_o = wb_q.data;
endmodule

// File: tb/tb_gpreg_wb_arbiter.sv
// Scoreboard bench for gpreg_wb_arbiter: directed scenarios plus random traffic
// checked against a search-order reference model.
module tb_gpreg_wb_arbiter;
    import riscv_pkg::*;
    import tortoise_pkg::*;

    localparam int N  = GPREG_WB_REQUESTERS;
    localparam int IW = $clog2(N);
    localparam int W  = 1 + $bits(reg_t) + $bits(data_t);

    logic              clk;
    logic              rst_ni;
    logic              flush;
    logic [N-1:0]      req_valid;
    reg_t  [N-1:0]     req_reg;
    data_t [N-1:0]     req_data;
    logic [N-1:0]      req_ready;
    logic              w_en;
    reg_t              w_reg;
    data_t             w_data;
    logic [IW-1:0]     grant_idx;

    int                checks;
    int                errors;
    logic [W-1:0]      exp_q[$];
    int                m_ptr;
    bit                mon_en;

    gpreg_wb_arbiter dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .flush_i    (flush),
        .req_valid_i(req_valid),
        .req_reg_i  (req_reg),
        .req_data_i (req_data),
        .req_ready_o(req_ready),
        .w_en_o     (w_en),
        .w_reg_o    (w_reg),
        .w_data_o   (w_data),
        .grant_idx_o(grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: scan requesters in search order from the model pointer.
    function automatic int model_grant(input logic [N-1:0] v);
        int start;
`ifdef GPREG_WB_FIXED_PRIO_EN
        start = 0;
`else
        start = m_ptr;
`endif
        for (int i = 0; i < N; i++) begin
            if (v[(start + i) % N]) return (start + i) % N;
        end
        return -1;
    endfunction

    task automatic drive_cycle(input logic [N-1:0] v, input reg_t [N-1:0] r,
                               input data_t [N-1:0] d, input bit fl, output int g);
        logic [N-1:0] exp_ready;
        @(negedge clk);
        req_valid = v;
        req_reg   = r;
        req_data  = d;
        flush     = fl;
        #1;
        g = fl ? -1 : model_grant(v);
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("ready", 64'(req_ready), 64'(exp_ready));
        if (g >= 0) chk("grant_idx", 64'(grant_idx), 64'(g));
        if (g >= 0 && r[g] != '0) exp_q.push_back({1'b1, r[g], d[g]});
        else                      exp_q.push_back('0);
        if (fl)          m_ptr = 0;
        else if (g >= 0) m_ptr = (g + 1) % N;
    endtask

    // Monitor: one expected entry per cycle, written the cycle before.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (mon_en && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("w_en", 64'(w_en), 64'(e[W-1]));
            if (e[W-1]) begin
                chk("w_reg", 64'(w_reg), 64'(e[W-2 -: 5]));
                chk("w_data", 64'(w_data), 64'(e[31:0]));
            end
        end
    end

    initial begin
        reg_t  [N-1:0] r;
        data_t [N-1:0] d;
        logic  [N-1:0] cur_v;
        int            wait_cnt [N];
        int            g;
        bit            fl;

        checks = 0; errors = 0; m_ptr = 0; mon_en = 0;
        rst_ni = 1'b0; flush = 1'b0; req_valid = '0; req_reg = '0; req_data = '0;
        r = '0; d = '0; cur_v = '0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;

        // Reset state
        #12;
        chk("rst_w_en", 64'(w_en), 0);
        chk("rst_ready", 64'(req_ready), 0);
        chk("rst_grant_idx", 64'(grant_idx), 0);
        @(negedge clk);
        rst_ni = 1'b1;
        mon_en = 1;

        // 1: idle after reset
        for (int i = 0; i < 5; i++) drive_cycle('0, r, d, 1'b0, g);
        chk("idle_w_reg", 64'(w_reg), 0);
        chk("idle_w_data", 64'(w_data), 0);

        // 2: single requester 2
        r[2] = 5'd7; d[2] = 32'hDEAD;
        drive_cycle(4'b0100, r, d, 1'b0, g);
        chk("t2_grant", 64'(g), 2);
        drive_cycle('0, r, d, 1'b0, g);
        chk("t2_w_en", 64'(w_en), 1);
        chk("t2_w_reg", 64'(w_reg), 7);
        chk("t2_w_data", 64'(w_data), 32'hDEAD);

        // 3: all valid from pointer 0 (flush to return pointer to 0)
        drive_cycle('0, r, d, 1'b1, g);
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < N; k++) begin
                r[k] = reg_t'($urandom_range(1, 31));
                d[k] = $urandom;
            end
            drive_cycle('1, r, d, 1'b0, g);
`ifdef GPREG_WB_FIXED_PRIO_EN
            chk("t3_grant", 64'(g), 0);
`else
            chk("t3_grant", 64'(g), 64'(i % N));
`endif
        end

        // 4: x0 destination is accepted but not written
        r[1] = '0; d[1] = 32'h55;
        drive_cycle(4'b0010, r, d, 1'b0, g);
        chk("t4_grant", 64'(g), 1);
        drive_cycle('0, r, d, 1'b0, g);
        chk("t4_w_en", 64'(w_en), 0);

        // 5: flush blocks grant and resets pointer
        drive_cycle(4'b1001, r, d, 1'b1, g);
        chk("t5_flush_grant", 64'(g + 1), 0);
        drive_cycle(4'b1001, r, d, 1'b0, g);
        chk("t5_grant", 64'(g), 0);

`ifdef GPREG_WB_FIXED_PRIO_EN
        // 6: fixed priority with 1 and 3 valid
        for (int i = 0; i < 3; i++) begin
            drive_cycle(4'b1010, r, d, 1'b0, g);
            chk("t6_grant", 64'(g), 1);
        end
`endif

        // Random traffic with producers holding until accepted
        cur_v = '0;
        for (int c = 0; c < 400; c++) begin
            fl = ($urandom_range(0, 15) == 0);
            drive_cycle(cur_v, r, d, fl, g);
            for (int i = 0; i < N; i++) begin
                if (cur_v[i] && i != g && !fl) wait_cnt[i]++;
                else                           wait_cnt[i] = 0;
`ifndef GPREG_WB_FIXED_PRIO_EN
                if (cur_v[i]) chk("fairness", 64'(wait_cnt[i] < N), 1);
`endif
                if (i == g || !cur_v[i]) begin
                    cur_v[i] = ($urandom_range(0, 3) != 0);
                    r[i] = ($urandom_range(0, 7) == 0) ? reg_t'(0) : reg_t'($urandom_range(1, 31));
                    d[i] = $urandom;
                end
            end
        end

        // Reset during an in-flight write
        r[0] = 5'd9; d[0] = $urandom;
        drive_cycle(4'b0001, r, d, 1'b0, g);
        @(posedge clk);
        #2;
        chk("mid_w_en_before", 64'(w_en), 1);
        rst_ni = 1'b0;
        req_valid = '0;
        exp_q.delete();
        #1;
        chk("mid_rst_w_en", 64'(w_en), 0);
        chk("mid_rst_w_reg", 64'(w_reg), 0);
        chk("mid_rst_w_data", 64'(w_data), 0);
        chk("mid_rst_ready", 64'(req_ready), 0);
        @(negedge clk);
        rst_ni = 1'b1;
        m_ptr = 0;
        r[3] = 5'd12; d[3] = 32'h1234_5678;
        drive_cycle(4'b1000, r, d, 1'b0, g);
        chk("post_rst_grant", 64'(g), 3);
        drive_cycle('0, r, d, 1'b0, g);
        @(negedge clk);
        #1;
        chk("drain", 64'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
